// File: rtl/sync_clk_counter_if.sv
// SyncClk bundle between the sync counter (producer) and the register/control side.
// The producer drives the counter/status fields; the control side drives the mode
// and error-clear requests.
interface sync_clk_counter_if #(
    parameter int COUNTER_SIZE = 19
);
    logic                    reset_cyclic;
    logic                    clear_error;
    logic [COUNTER_SIZE-1:0] sync_counter;
    logic                    error_flag;
    logic                    sync_pulse;
    logic [COUNTER_SIZE-1:0] period_last;
    logic                    locked;

    modport master (
        input  reset_cyclic,
        input  clear_error,
        output sync_counter,
        output error_flag,
        output sync_pulse,
        output period_last,
        output locked
    );

    modport slave (
        output reset_cyclic,
        output clear_error,
        input  sync_counter,
        input  error_flag,
        input  sync_pulse,
        input  period_last,
        input  locked
    );
endinterface

// File: rtl/sync_clk_counter.sv
// Sync clock counter: counts clk cycles between external sync pulses, locks to
// them, and flags early or missing pulses against a nominal period +/- tolerance.
// The sync input is asynchronous and passes through a 2-FF synchroniser plus a
// delay flop for rising-edge detection (3-cycle input-to-counter latency).
module sync_clk_counter #(
    parameter int COUNTER_SIZE = 19,
    parameter int PERIOD       = 500000,
    parameter int TOL          = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_in,
    sync_clk_counter_if.master    bus
);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    localparam int WIN_LOW_I  = PERIOD - 32'sd1 - TOL;
    localparam int WIN_HIGH_I = PERIOD - 32'sd1 + TOL;
    localparam logic [COUNTER_SIZE-1:0] WIN_LOW  = WIN_LOW_I[COUNTER_SIZE-1:0];
    localparam logic [COUNTER_SIZE-1:0] WIN_HIGH = WIN_HIGH_I[COUNTER_SIZE-1:0];
    localparam logic [COUNTER_SIZE-1:0] CNT_ZERO = {COUNTER_SIZE{1'b0}};
    localparam logic [COUNTER_SIZE-1:0] CNT_ONE  = {{(COUNTER_SIZE-1){1'b0}}, 1'b1};

    logic                    syncMeta_r;
    logic                    syncQ_r;
    logic                    syncQd_r;
    logic                    edge_s;

    state_t                  state_r;
    state_t                  stateNext_s;
    logic [COUNTER_SIZE-1:0] count_r;
    logic [COUNTER_SIZE-1:0] countNext_s;
    logic [COUNTER_SIZE-1:0] periodLast_r;
    logic [COUNTER_SIZE-1:0] periodLastNext_s;
    logic                    pulse_r;
    logic                    pulseNext_s;
    logic                    error_r;
    logic                    errorNext_s;
    logic                    errorSet_s;
    logic                    locked_r;

    // Resynchronise the asynchronous sync input and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncMeta_r <= 1'b0;
            syncQ_r    <= 1'b0;
            syncQd_r   <= 1'b0;
        end else begin
            syncMeta_r <= sync_in;
            syncQ_r    <= syncMeta_r;
            syncQd_r   <= syncQ_r;
        end
    end

    assign edge_s = syncQ_r & ~syncQd_r;

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= UNLOCKED;
            count_r      <= CNT_ZERO;
            periodLast_r <= CNT_ZERO;
            pulse_r      <= 1'b0;
            error_r      <= 1'b0;
            locked_r     <= 1'b0;
        end else begin
            state_r      <= stateNext_s;
            count_r      <= countNext_s;
            periodLast_r <= periodLastNext_s;
            pulse_r      <= pulseNext_s;
            error_r      <= errorNext_s;
            locked_r     <= (stateNext_s == LOCKED);
        end
    end

    // Next-state, counter and period-check decisions.
    always_comb begin
        stateNext_s      = state_r;
        countNext_s      = count_r + CNT_ONE;
        periodLastNext_s = periodLast_r;
        pulseNext_s      = 1'b0;
        errorSet_s       = 1'b0;

        if (!bus.reset_cyclic) begin
            // Free-run: only the period capture follows the edges.
            stateNext_s = UNLOCKED;
            if (edge_s) begin
                periodLastNext_s = count_r;
            end else begin
                periodLastNext_s = periodLast_r;
            end
        end else begin
            case (state_r)
                UNLOCKED: begin
                    if (edge_s) begin
                        countNext_s      = CNT_ZERO;
                        pulseNext_s      = 1'b1;
                        periodLastNext_s = count_r;
                        stateNext_s      = LOCKED;
                    end else begin
                        stateNext_s = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (edge_s) begin
                        // An edge always resyncs; it is an error only if it is early.
                        // An edge at the window top beats the missing-pulse flywheel.
                        countNext_s      = CNT_ZERO;
                        pulseNext_s      = 1'b1;
                        periodLastNext_s = count_r;
                        if (count_r < WIN_LOW) begin
                            errorSet_s = 1'b1;
                        end else begin
                            errorSet_s = 1'b0;
                        end
                    end else if (count_r >= WIN_HIGH) begin
                        // Missing pulse: flywheel back to zero and stay locked.
                        countNext_s = CNT_ZERO;
                        errorSet_s  = 1'b1;
                    end else begin
                        countNext_s = count_r + CNT_ONE;
                    end
                end
                default: begin
                    stateNext_s = UNLOCKED;
                end
            endcase
        end

        // Sticky error: a new event takes priority over a clear request.
        if (errorSet_s) begin
            errorNext_s = 1'b1;
        end else if (bus.clear_error) begin
            errorNext_s = 1'b0;
        end else begin
            errorNext_s = error_r;
        end
    end

    assign bus.sync_counter = count_r;
    assign bus.period_last  = periodLast_r;
    assign bus.sync_pulse   = pulse_r;
    assign bus.error_flag   = error_r;
    assign bus.locked       = locked_r;

endmodule

// File: tb/tb_sync_clk_counter.sv
// Self-checking bench for sync_clk_counter with COUNTER_SIZE=5, PERIOD=10, TOL=1
// (acceptance window 8..10). A cycle-level reference model tracks elapsed counts,
// lock status and the sticky error from the sampled sync history.
module tb_sync_clk_counter;

    localparam int CS     = 5;
    localparam int PER    = 10;
    localparam int TOLV   = 1;
    localparam int WLO    = PER - 1 - TOLV;
    localparam int WHI    = PER - 1 + TOLV;
    localparam int MODV   = 1 << CS;

    logic clk;
    logic reset_n;
    logic sync_in;

    sync_clk_counter_if #(.COUNTER_SIZE(CS)) bus ();

    sync_clk_counter #(
        .COUNTER_SIZE(CS),
        .PERIOD(PER),
        .TOL(TOLV)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sync_in(sync_in),
        .bus(bus.master)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int   mCount;
    int   mPeriodLast;
    bit   mPulse;
    bit   mErr;
    bit   mLocked;
    bit   hist [0:2];
    bit   rcVal;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        mCount = 0; mPeriodLast = 0; mPulse = 1'b0; mErr = 1'b0; mLocked = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 1'b0;
    endtask

    // One clock of the reference model, given the inputs sampled at this edge.
    task automatic modelTick(input bit s, input bit clr, input bit rc);
        bit edgeSeen;
        bit setErr;
        edgeSeen = hist[1] && !hist[2];
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = s;
        setErr = 1'b0;
        mPulse = 1'b0;
        if (!rc) begin
            mLocked = 1'b0;
            if (edgeSeen) mPeriodLast = mCount;
            mCount = (mCount + 1) % MODV;
        end else if (!mLocked) begin
            if (edgeSeen) begin
                mPeriodLast = mCount; mCount = 0; mPulse = 1'b1; mLocked = 1'b1;
            end else begin
                mCount = (mCount + 1) % MODV;
            end
        end else begin
            if (edgeSeen) begin
                if (mCount < WLO) setErr = 1'b1;
                mPeriodLast = mCount; mCount = 0; mPulse = 1'b1;
            end else if (mCount == WHI) begin
                mCount = 0; setErr = 1'b1;
            end else begin
                mCount = mCount + 1;
            end
        end
        if (setErr) mErr = 1'b1;
        else if (clr) mErr = 1'b0;
    endtask

    task automatic checkAll();
        chk("sync_counter", bus.sync_counter, mCount);
        chk("period_last",  bus.period_last,  mPeriodLast);
        chk("sync_pulse",   bus.sync_pulse,   mPulse);
        chk("error_flag",   bus.error_flag,   mErr);
        chk("locked",       bus.locked,       mLocked);
    endtask

    task automatic step(input bit s, input bit clr);
        sync_in = s;
        bus.clear_error = clr;
        bus.reset_cyclic = rcVal;
        @(posedge clk);
        modelTick(s, clr, rcVal);
        #1;
        checkAll();
    endtask

    // Sync pulse high for 2 cycles, next rise 'gap' cycles after this one.
    // clrAt selects the step (0-based) that also raises clear_error, -1 for none.
    task automatic pulse(input int gap, input int clrAt);
        for (int i = 0; i < gap; i++) step(i < 2, i == clrAt);
    endtask

    initial begin
        reset_n = 1'b0;
        sync_in = 1'b0;
        rcVal = 1'b1;
        bus.reset_cyclic = 1'b1;
        bus.clear_error = 1'b0;
        modelReset();
        #12;
        chk("rst_counter", bus.sync_counter, 0);
        chk("rst_period",  bus.period_last, 0);
        chk("rst_pulse",   bus.sync_pulse, 0);
        chk("rst_error",   bus.error_flag, 0);
        chk("rst_locked",  bus.locked, 0);
        reset_n = 1'b1;

        // Regular pulses every 10 cycles
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) pulse(PER, -1);
        chk("t1_period", bus.period_last, 9);
        chk("t1_locked", bus.locked, 1);
        chk("t1_error",  bus.error_flag, 0);

        // Early pulse: counter=4 at the edge
        pulse(5, -1);
        pulse(PER, -1);
        chk("t2_period", bus.period_last, 4);
        chk("t2_error",  bus.error_flag, 1);
        chk("t2_locked", bus.locked, 1);
        step(1'b0, 1'b1);
        chk("t2_clear", bus.error_flag, 0);

        // Missing pulses: flywheel every 11 cycles
        for (int i = 0; i < 35; i++) step(1'b0, 1'b0);
        chk("t3_error",  bus.error_flag, 1);
        chk("t3_locked", bus.locked, 1);

        // Window boundaries and clear/set priority
        pulse(PER, -1);
        pulse(PER, -1);
        step(1'b0, 1'b1);
        pulse(11, -1);
        pulse(8, -1);
        chk("t4_edge10_period", bus.period_last, 10);
        chk("t4_edge10_error",  bus.error_flag, 0);
        pulse(PER, -1);
        chk("t4_edge7_period", bus.period_last, 7);
        chk("t4_edge7_error",  bus.error_flag, 1);
        step(1'b0, 1'b1);
        chk("t4_cleared", bus.error_flag, 0);
        pulse(5, -1);
        pulse(PER, 2);
        chk("t4_setwins", bus.error_flag, 1);
        step(1'b0, 1'b1);
        chk("t4_clear_alone", bus.error_flag, 0);

        // Randomised locked-mode pulse spacing with occasional clears
        for (int i = 0; i < 20; i++)
            pulse($urandom_range(6, 13), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1);

        // Free-run mode
        rcVal = 1'b0;
        step(1'b0, 1'b1);
        chk("t5_locked", bus.locked, 0);
        for (int i = 0; i < 8; i++) pulse($urandom_range(3, 15), -1);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0);
        chk("t5_error", bus.error_flag, 0);

        // Async reset mid-period
        rcVal = 1'b1;
        for (int i = 0; i < 3; i++) pulse(PER, -1);
        for (int i = 0; i < 40 && mCount != 6; i++) step(1'b0, 1'b0);
        chk("t6_reach6", bus.sync_counter, 6);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_counter", bus.sync_counter, 0);
        chk("t6_period",  bus.period_last, 0);
        chk("t6_pulse",   bus.sync_pulse, 0);
        chk("t6_error",   bus.error_flag, 0);
        chk("t6_locked",  bus.locked, 0);
        modelReset();
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        chk("t6_nolock", bus.locked, 0);
        pulse(PER, -1);
        pulse(PER, -1);
        chk("t6_relock", bus.locked, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
